// File: rtl/combo_lock_fsm_param.sv
// Parametrised combination-lock controller with failed-attempt lockout and code re-programming.
// Latency: outputs are a decode of registered state/counters, valid right after the deciding edge.
// Backpressure: none; digit_valid is a one-cycle strobe and digits outside ENTRY/PROG are dropped.
//
// Ports:
//   i_clk, i_reset       rising-edge clock, asynchronous active-high reset
//   i_digit_in           entered digit, sampled when i_digit_valid=1
//   i_digit_valid        one-cycle strobe per entered digit
//   i_clear              back to ENTRY from CLOSED/ERROR/OPEN (restarts ENTRY); aborts PROG to OPEN
//   i_prog_en            level; in OPEN moves to PROG on the next edge
//   o_open/o_closed/o_error/o_locked_out/o_prog_active   one-hot state flags
//   o_digit_count        digits accepted in the current ENTRY/PROG sequence
//   o_fail_count         consecutive failed attempts
module combo_lock_fsm_param #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 6,
  parameter int MAX_DIGIT   = 9,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h483815,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 16,
  localparam int CNT_W      = $clog2(CODE_LEN+1),
  localparam int FAIL_W     = $clog2(MAX_TRIES+1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DIGIT_W-1:0] i_digit_in,
  input  logic               i_digit_valid,
  input  logic               i_clear,
  input  logic               i_prog_en,
  output logic               o_open,
  output logic               o_closed,
  output logic               o_error,
  output logic               o_locked_out,
  output logic               o_prog_active,
  output logic [CNT_W-1:0]   o_digit_count,
  output logic [FAIL_W-1:0]  o_fail_count
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int TMR_W  = $clog2(LOCKOUT_CYC+1);

  localparam logic [DIGIT_W-1:0] MAX_D     = DIGIT_W'(MAX_DIGIT);
  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(CODE_LEN-1);
  localparam logic [FAIL_W-1:0]  TRIES_LIM = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]   TMR_INIT  = TMR_W'(LOCKOUT_CYC);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_OPEN,
    S_CLOSED,
    S_ERROR,
    S_LOCKOUT,
    S_PROG
  } state_t;

  state_t              r_state;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_shadow;
  logic [CNT_W-1:0]    r_count;
  logic [FAIL_W-1:0]   r_fail;
  logic [TMR_W-1:0]    r_timer;
  logic                r_mismatch;

  logic                w_legal;
  logic                w_last;
  logic                w_mis_next;
  logic [DIGIT_W-1:0]  w_exp;
  logic [FAIL_W-1:0]   w_fail_inc;
  logic [CODE_W-1:0]   w_shadow_nxt;

  assign w_legal      = (i_digit_in <= MAX_D);
  assign w_last       = (r_count == LAST_IDX);
  assign w_fail_inc   = r_fail + FAIL_W'(1);
  // Mismatch is accumulated so a wrong early digit is only reported after the full code.
  assign w_mis_next   = r_mismatch | (i_digit_in != w_exp);
  // New digits enter at the LS end so the first digit ends up in the MS position.
  assign w_shadow_nxt = (r_shadow << DIGIT_W) | CODE_W'(i_digit_in);

  // Stored digit at the current entry position; first digit lives in the MS slot.
  always_comb begin
    w_exp = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_count == CNT_W'(i)) begin
        w_exp = r_code[CODE_W-1-i*DIGIT_W -: DIGIT_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_ENTRY;
      r_code     <= DEFAULT_CODE;
      r_shadow   <= '0;
      r_count    <= '0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        S_ENTRY: begin
          // Clear restarts the sequence and discards a same-edge digit.
          if (i_clear) begin
            r_count    <= '0;
            r_mismatch <= 1'b0;
          end else if (i_digit_valid) begin
            if (!w_legal) begin
              r_state <= S_ERROR;
            end else begin
              r_count    <= r_count + CNT_W'(1);
              r_mismatch <= w_mis_next;
              if (w_last) begin
                if (!w_mis_next) begin
                  r_state <= S_OPEN;
                  r_fail  <= '0;
                end else if (w_fail_inc == TRIES_LIM) begin
                  r_state <= S_LOCKOUT;
                  r_fail  <= w_fail_inc;
                  r_timer <= TMR_INIT;
                end else begin
                  r_state <= S_CLOSED;
                  r_fail  <= w_fail_inc;
                end
              end
            end
          end
        end

        S_CLOSED, S_ERROR: begin
          if (i_clear) begin
            r_state    <= S_ENTRY;
            r_count    <= '0;
            r_mismatch <= 1'b0;
          end
        end

        // Inputs are ignored; timer loaded with LOCKOUT_CYC leaves after exactly that many cycles.
        S_LOCKOUT: begin
          if (r_timer == TMR_W'(1)) begin
            r_state    <= S_ENTRY;
            r_fail     <= '0;
            r_count    <= '0;
            r_mismatch <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        S_OPEN: begin
          if (i_clear) begin
            r_state    <= S_ENTRY;
            r_count    <= '0;
            r_mismatch <= 1'b0;
          end else if (i_prog_en) begin
            r_state <= S_PROG;
            r_count <= '0;
          end
        end

        // The live code only changes on the final legal digit, so an abort leaves it intact.
        S_PROG: begin
          if (i_clear) begin
            r_state <= S_OPEN;
            r_count <= '0;
          end else if (i_digit_valid) begin
            if (!w_legal) begin
              r_state <= S_OPEN;
              r_count <= '0;
            end else begin
              r_shadow <= w_shadow_nxt;
              if (w_last) begin
                r_code  <= w_shadow_nxt;
                r_state <= S_OPEN;
                r_count <= '0;
              end else begin
                r_count <= r_count + CNT_W'(1);
              end
            end
          end
        end

        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign o_open        = (r_state == S_OPEN);
  assign o_closed      = (r_state == S_CLOSED);
  assign o_error       = (r_state == S_ERROR);
  assign o_locked_out  = (r_state == S_LOCKOUT);
  assign o_prog_active = (r_state == S_PROG);
  assign o_digit_count = r_count;
  assign o_fail_count  = r_fail;

endmodule
